// File: rtl/serial_magnitude_comparator.sv
// ============================================================================
// Module   : serial_magnitude_comparator
// Brief    : Bit-serial MSB-first magnitude comparator with one-hot eq/gt/lt.
//            Define SERIAL_CMP_SIGNED_EN for two's complement operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int C_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [C_IDX_W-1:0] idx_q, idx_d;
    logic               dec_vld_q, dec_vld_d;
    logic               dec_gt_q, dec_gt_d;
    logic               done_q, done_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;

    logic               w_bit_a;
    logic               w_bit_b;
    logic               w_differ;
    logic               w_bit_gt;
    logic               w_finish;

    assign w_bit_a  = a_q[idx_q];
    assign w_bit_b  = b_q[idx_q];
    assign w_differ = w_bit_a ^ w_bit_b;

`ifdef SERIAL_CMP_SIGNED_EN
    localparam logic [C_IDX_W-1:0] C_IDX_MSB = C_IDX_W'(WIDTH - 1);
    // A set sign bit means negative, so the MSB decision is inverted.
    assign w_bit_gt = (idx_q == C_IDX_MSB) ? w_bit_b : w_bit_a;
`else
    assign w_bit_gt = w_bit_a;
`endif

    assign w_finish = ((EARLY_EXIT != 0) && w_differ) || (idx_q == '0);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        dec_vld_d = dec_vld_q;
        dec_gt_d  = dec_gt_q;
        done_d    = 1'b0;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    a_d       = a;
                    b_d       = b;
                    idx_d     = C_IDX_W'(WIDTH - 1);
                    dec_vld_d = 1'b0;
                    dec_gt_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (!dec_vld_q && w_differ) begin
                    dec_vld_d = 1'b1;
                    dec_gt_d  = w_bit_gt;
                end
                if (w_finish) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    eq_d    = !dec_vld_d;
                    gt_d    = dec_vld_d && dec_gt_d;
                    lt_d    = dec_vld_d && !dec_gt_d;
                end else begin
                    idx_d = idx_q - C_IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            dec_vld_q <= 1'b0;
            dec_gt_q  <= 1'b0;
            done_q    <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            dec_vld_q <= dec_vld_d;
            dec_gt_q  <= dec_gt_d;
            done_q    <= done_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
// ============================================================================
// Module   : tb_serial_magnitude_comparator
// Brief    : Directed bench; early-exit and full-scan instances share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_magnitude_comparator;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a     = 8'h00;
    logic [7:0] b     = 8'h00;

    logic busy1, done1, eq1, gt1, lt1;
    logic busy0, done0, eq0, gt0, lt0;

    int n_assert = 0;
    int n_fail   = 0;

    serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1)) u_ee1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
    );

    serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(0)) u_ee0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .lt(lt0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a comparison from the current (off-edge) time and reports the
    // done latency of each instance (-1 if none within the window).
    task automatic run(input logic [7:0] av, input logic [7:0] bv,
                       input int inj_edge, input int rst_edge,
                       output int lat1, output int lat0,
                       output int pulses1, output int busycnt);
        lat1 = -1; lat0 = -1; pulses1 = 0; busycnt = 0;
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy1) busycnt++;
        for (int n = 1; n <= 24; n++) begin
            if (n == inj_edge) begin
                a = 8'hFF; b = 8'h00; start = 1'b1;
            end
            @(posedge clk); #1;
            if (n == inj_edge) start = 1'b0;
            if (busy1) busycnt++;
            if (done1) begin
                pulses1++;
                if (lat1 < 0) begin
                    lat1 = n;
                    chk("busy_clear_on_done", 32'(busy1), 32'd0);
                end
            end
            if (done0 && lat0 < 0) lat0 = n;
            if (rst_edge > 0 && n == rst_edge) begin
                rst_n = 1'b0;
                #1;
                chk("async_rst_ee1", 32'({busy1, done1, eq1, gt1, lt1}), 32'd0);
                chk("async_rst_ee0", 32'({busy0, done0, eq0, gt0, lt0}), 32'd0);
            end
            if (rst_edge > 0 && n == rst_edge + 2) rst_n = 1'b1;
            if (lat1 >= 0 && lat0 >= 0) break;
        end
    endtask

    initial begin
        int l1, l0, p1, bc, bad;

        // Reset state
        #1;
        chk("reset_ee1", 32'({busy1, done1, eq1, gt1, lt1}), 32'd0);
        chk("reset_ee0", 32'({busy0, done0, eq0, gt0, lt0}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: equal operands scan the full width
        run(8'hA5, 8'hA5, 0, 0, l1, l0, p1, bc);
        chk("t1_lat_ee1", 32'(l1), 32'd8);
        chk("t1_lat_ee0", 32'(l0), 32'd8);
        chk("t1_busy_cycles", 32'(bc), 32'd8);
        chk("t1_pulses", 32'(p1), 32'd1);
        chk("t1_flags_ee1", 32'({eq1, gt1, lt1}), 32'b100);
        chk("t1_flags_ee0", 32'({eq0, gt0, lt0}), 32'b100);

        // 2: MSB decides
        run(8'h80, 8'h7F, 0, 0, l1, l0, p1, bc);
        chk("t2_lat_ee1", 32'(l1), 32'd1);
        chk("t2_lat_ee0", 32'(l0), 32'd8);
        chk("t2_pulses", 32'(p1), 32'd1);
`ifdef SERIAL_CMP_SIGNED_EN
        chk("t2_flags_ee1", 32'({eq1, gt1, lt1}), 32'b001);
        chk("t2_flags_ee0", 32'({eq0, gt0, lt0}), 32'b001);
`else
        chk("t2_flags_ee1", 32'({eq1, gt1, lt1}), 32'b010);
        chk("t2_flags_ee0", 32'({eq0, gt0, lt0}), 32'b010);
`endif

        // 3: LSB decides, then restart in the done cycle
        run(8'h12, 8'h13, 0, 0, l1, l0, p1, bc);
        chk("t3a_lat_ee1", 32'(l1), 32'd8);
        chk("t3a_flags_ee1", 32'({eq1, gt1, lt1}), 32'b001);
        chk("t3a_done_now", 32'(done1), 32'd1);
        run(8'h40, 8'h10, 0, 0, l1, l0, p1, bc);
        chk("t3b_lat_ee1", 32'(l1), 32'd2);
        chk("t3b_lat_ee0", 32'(l0), 32'd8);
        chk("t3b_flags_ee1", 32'({eq1, gt1, lt1}), 32'b010);
        chk("t3b_flags_ee0", 32'({eq0, gt0, lt0}), 32'b010);

        // 4: full scan has constant latency; flags hold while idle
        run(8'hF0, 8'h0F, 0, 0, l1, l0, p1, bc);
        chk("t4_lat_ee0", 32'(l0), 32'd8);
        chk("t4_lat_ee1", 32'(l1), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
`ifdef SERIAL_CMP_SIGNED_EN
            if ({eq0, gt0, lt0, busy0, done0} !== 5'b00100) bad++;
`else
            if ({eq0, gt0, lt0, busy0, done0} !== 5'b01000) bad++;
`endif
        end
        chk("t4_hold_cycles_bad", 32'(bad), 32'd0);

        // 5: start while busy is ignored
        run(8'h01, 8'h02, 3, 0, l1, l0, p1, bc);
        chk("t5_lat_ee1", 32'(l1), 32'd7);
        chk("t5_lat_ee0", 32'(l0), 32'd8);
        chk("t5_flags_ee1", 32'({eq1, gt1, lt1}), 32'b001);
        chk("t5_flags_ee0", 32'({eq0, gt0, lt0}), 32'b001);

        // 6: reset mid-operation aborts without done
        run(8'h00, 8'h01, 0, 4, l1, l0, p1, bc);
        chk("t6_no_done_ee1", 32'(l1), 32'hFFFF_FFFF);
        chk("t6_no_done_ee0", 32'(l0), 32'hFFFF_FFFF);
        chk("t6_flags_after", 32'({eq1, gt1, lt1, eq0, gt0, lt0}), 32'd0);
        run(8'h33, 8'h35, 0, 0, l1, l0, p1, bc);
        chk("t6_lat_ee1", 32'(l1), 32'd6);
        chk("t6_lat_ee0", 32'(l0), 32'd8);
        chk("t6_flags_ee1", 32'({eq1, gt1, lt1}), 32'b001);
        chk("t6_flags_ee0", 32'({eq0, gt0, lt0}), 32'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
